esc_pwm_array: RTL

//  N-channel ESC PWM generator for the quadcopter motor outputs. Sits between the

---
 rtl/esc_pkg.sv | 19 +
 rtl/esc_pwm_channel.sv | 69 ++++++
 rtl/esc_pwm_array.sv | 125 ++++++++++++
 3 files changed

// File: rtl/esc_pkg.sv
// Shared types and default timing constants for the ESC PWM array.
package esc_pkg;

    // Arming state machine encoding, also exported on the state output.
    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        RUN      = 2'd2,
        FAILSAFE = 2'd3
    } esc_state_t;

    // 2 ms frame at 50 MHz.
    localparam int PERIOD_2MS    = 100000;
    // Mixer strobes held at idle speed before the motors may spin up.
    localparam int ARM_UPD_DEF   = 1000;
    // 100 ms at 50 MHz without a mixer update before failsafe.
    localparam int TIMEOUT_100MS = 5000000;

endpackage

// File: rtl/esc_pwm_channel.sv
// One ESC output: clamps the mixer speed word into a shadow duty, transfers it
// to the active duty only at the frame boundary, and compares against the
// shared frame counter to produce a registered pulse.
module esc_pwm_channel
    import esc_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             frame_end_i,
    input  logic             speed_oe_i,
    input  logic [IN_W-1:0]  speed_i,
    input  logic             use_min_i,
    input  logic [CNT_W-1:0] min_speed_i,
    input  logic [CNT_W-1:0] max_speed_i,
    output logic             pwm_o
);

    localparam int SUM_W = CNT_W + 1;

    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] clamped;
    logic [CNT_W-1:0] source;
    logic [CNT_W-1:0] shadow_q;
    logic [CNT_W-1:0] active_q;
    logic             pwm_q;

    // Speed plus idle offset is formed one bit wider so a large speed word
    // saturates at the ceiling instead of wrapping to a short pulse.
    assign sum     = {1'b0, min_speed_i} + SUM_W'(speed_i);
    assign clamped = (sum > {1'b0, max_speed_i}) ? max_speed_i : sum[CNT_W-1:0];

    // A misconfigured floor above the ceiling pins every source to the ceiling.
    assign source = (min_speed_i > max_speed_i) ? max_speed_i :
                    (use_min_i ? min_speed_i : shadow_q);

    // Capture every mixer update, regardless of arming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (speed_oe_i) begin
            shadow_q <= clamped;
        end
    end

    // Active duty only changes on the last cycle of a frame, keeping pulses whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
        end else if (frame_end_i) begin
            active_q <= source;
        end
    end

    // Registered compare so the pin never glitches while duty or counter move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= (cnt_i < active_q);
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/esc_pwm_array.sv
// N-channel ESC PWM generator: shared frame counter, arm/run/failsafe state
// machine with its arm and timeout counters, and one channel per motor.
module esc_pwm_array
    import esc_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int IN_W    = 16,
    parameter int CNT_W   = 20,
    parameter int PERIOD  = PERIOD_2MS,
    parameter int ARM_UPD = ARM_UPD_DEF,
    parameter int TIMEOUT = TIMEOUT_100MS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH*IN_W-1:0] speed_in,
    input  logic                 speed_oe,
    input  logic                 arm,
    input  logic [CNT_W-1:0]     min_speed,
    input  logic [CNT_W-1:0]     max_speed,
    output logic [N_CH-1:0]      pwm,
    output logic [1:0]           state,
    output logic                 frame_start,
    output logic                 failsafe
);

    localparam int ARM_W = $clog2(ARM_UPD + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             frame_start_q;
    logic             frameEnd;
    esc_state_t       state_q;
    logic [ARM_W-1:0] armCnt_q;
    logic [TO_W-1:0]  toCnt_q;
    logic             failsafe_q;
    logic             useMin;

    assign frameEnd = (cnt_q == CNT_W'(PERIOD - 1));
    assign useMin   = (state_q != RUN);

    // Free-running frame counter; frame_start is registered so it reads 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= frameEnd ? '0 : cnt_q + 1'b1;
            frame_start_q <= frameEnd;
        end
    end

    // Arm/run/failsafe sequencing; dropping arm overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DISARMED;
            armCnt_q   <= '0;
            toCnt_q    <= '0;
            failsafe_q <= 1'b0;
        end else if (!arm) begin
            state_q    <= DISARMED;
            armCnt_q   <= '0;
            toCnt_q    <= '0;
            failsafe_q <= 1'b0;
        end else begin
            case (state_q)
                DISARMED: begin
                    state_q  <= ARMING;
                    armCnt_q <= '0;
                    toCnt_q  <= '0;
                end
                ARMING: begin
                    if (speed_oe) begin
                        if (armCnt_q == ARM_W'(ARM_UPD - 1)) begin
                            state_q  <= RUN;
                            armCnt_q <= '0;
                            toCnt_q  <= '0;
                        end else begin
                            armCnt_q <= armCnt_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (speed_oe) begin
                        toCnt_q <= '0;
                    end else if (toCnt_q == TO_W'(TIMEOUT - 1)) begin
                        state_q    <= FAILSAFE;
                        toCnt_q    <= '0;
                        failsafe_q <= 1'b1;
                    end else begin
                        toCnt_q <= toCnt_q + 1'b1;
                    end
                end
                FAILSAFE: begin
                    failsafe_q <= 1'b1;
                end
                default: begin
                    state_q <= DISARMED;
                end
            endcase
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        esc_pwm_channel #(
            .IN_W  (IN_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .cnt_i       (cnt_q),
            .frame_end_i (frameEnd),
            .speed_oe_i  (speed_oe),
            .speed_i     (speed_in[ch*IN_W +: IN_W]),
            .use_min_i   (useMin),
            .min_speed_i (min_speed),
            .max_speed_i (max_speed),
            .pwm_o       (pwm[ch])
        );
    end

    assign state       = state_q;
    assign frame_start = frame_start_q;
    assign failsafe    = failsafe_q;

endmodule
